// File: rtl/fan_pwm_generator_if.sv
// -----------------------------------------------------------------------------
// fan_pwm_generator_if
// Bundles the fan PWM generator's functional signals.
//   tick_in    : multiplier tick, asynchronous to the generator clock
//   speed_sel  : 2-bit speed level (0 off, 1 low, 2 mid, 3 high)
//   pwm_out    : registered fan gate drive
//   duty_cur   : duty in effect for the current frame
//   frame_done : one-cycle pulse on each frame wrap
//   busy       : high while the duty is ramping toward its target
// Modports: master drives tick/speed and observes outputs; slave is the
// generator itself.
// -----------------------------------------------------------------------------
interface fan_pwm_generator_if #(
  parameter int DUTY_W = 7
);
  logic              tick_in;
  logic [1:0]        speed_sel;
  logic              pwm_out;
  logic [DUTY_W-1:0] duty_cur;
  logic              frame_done;
  logic              busy;

  modport master (
    output tick_in, speed_sel,
    input  pwm_out, duty_cur, frame_done, busy
  );

  modport slave (
    input  tick_in, speed_sel,
    output pwm_out, duty_cur, frame_done, busy
  );
endinterface

// File: rtl/fan_pwm_generator.sv
// -----------------------------------------------------------------------------
// fan_pwm_generator
// Counts synchronised multiplier ticks into a PERIOD-tick frame and drives the
// fan gate high while the frame count is below the active duty. The duty is
// chosen by speed_sel and only changes on frame wraps.
//
// Ports:
//   clk_in : system clock, rising edge
//   rst    : synchronous active-high reset
//   bus    : fan_pwm_generator_if.slave (tick_in, speed_sel in;
//            pwm_out, duty_cur, frame_done, busy out)
//
// Build option: FAN_SOFTSTART_EN
//   defined   -> duty steps toward its target by RAMP_STEP once per frame,
//                busy flags the RAMP state
//   undefined -> duty jumps straight to the target at each wrap, busy is 0
// -----------------------------------------------------------------------------
module fan_pwm_generator #(
  parameter int PERIOD    = 100,
  parameter int DUTY_W    = 7,
  parameter int RAMP_STEP = 5,
  parameter int LOW_DUTY  = 30,
  parameter int MID_DUTY  = 60,
  parameter int HIGH_DUTY = 100
) (
  input  logic                clk_in,
  input  logic                rst,
  fan_pwm_generator_if.slave  bus
);

  // Level duties clamped to the frame length so no duty can exceed PERIOD.
  localparam logic [DUTY_W-1:0] LOW_C  = DUTY_W'((LOW_DUTY  > PERIOD) ? PERIOD : LOW_DUTY);
  localparam logic [DUTY_W-1:0] MID_C  = DUTY_W'((MID_DUTY  > PERIOD) ? PERIOD : MID_DUTY);
  localparam logic [DUTY_W-1:0] HIGH_C = DUTY_W'((HIGH_DUTY > PERIOD) ? PERIOD : HIGH_DUTY);
  localparam logic [DUTY_W-1:0] LAST_C = DUTY_W'(PERIOD - 1);
  localparam logic [DUTY_W-1:0] ONE_C  = DUTY_W'(1);
  localparam logic [DUTY_W-1:0] ZERO_C = DUTY_W'(0);

`ifdef FAN_SOFTSTART_EN
  localparam logic [DUTY_W:0] STEP_C = (DUTY_W+1)'(RAMP_STEP);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_RAMP = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // One ramp step from cur toward tgt, computed one bit wider and saturated
  // at tgt so it can never overshoot, underflow below 0 or exceed PERIOD.
  function automatic logic [DUTY_W-1:0] step_toward(
    input logic [DUTY_W-1:0] cur,
    input logic [DUTY_W-1:0] tgt
  );
    logic [DUTY_W:0]   cur_w;
    logic [DUTY_W:0]   tgt_w;
    logic [DUTY_W:0]   sum_w;
    logic [DUTY_W:0]   floor_w;
    logic [DUTY_W:0]   diff_w;
    logic [DUTY_W-1:0] res;
    cur_w   = {1'b0, cur};
    tgt_w   = {1'b0, tgt};
    sum_w   = cur_w + STEP_C;
    floor_w = tgt_w + STEP_C;
    diff_w  = cur_w - STEP_C;
    if (cur < tgt) begin
      res = (sum_w >= tgt_w) ? tgt : sum_w[DUTY_W-1:0];
    end else if (cur > tgt) begin
      res = (cur_w <= floor_w) ? tgt : diff_w[DUTY_W-1:0];
    end else begin
      res = tgt;
    end
    return res;
  endfunction
`else
  typedef enum logic [0:0] {
    ST_OFF = 1'b0,
    ST_RUN = 1'b1
  } state_t;
`endif

  logic              sync1_r, sync2_r, edge_r;
  logic              tick_s;
  logic [DUTY_W-1:0] cnt_r, cnt_next_s;
  logic              wrap_s;
  logic [DUTY_W-1:0] target_s;
  logic [DUTY_W-1:0] duty_r, duty_next_s;
  logic [DUTY_W-1:0] duty_base_s;
  state_t            state_r, state_next_s;
  logic              pwm_r, frame_done_r, busy_r;

  // Two-stage synchroniser plus previous-value flop for rising-edge detect.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      edge_r  <= 1'b0;
    end else begin
      sync1_r <= bus.tick_in;
      sync2_r <= sync1_r;
      edge_r  <= sync2_r;
    end
  end

  // A held-high tick_in produces only one pulse.
  assign tick_s = sync2_r & ~edge_r;

  // Frame counter next value and wrap detection.
  always_comb begin
    cnt_next_s = cnt_r;
    wrap_s     = 1'b0;
    if (tick_s) begin
      if (cnt_r == LAST_C) begin
        cnt_next_s = ZERO_C;
        wrap_s     = 1'b1;
      end else begin
        cnt_next_s = cnt_r + ONE_C;
      end
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Clamped duty for the requested speed level.
  always_comb begin
    target_s = ZERO_C;
    case (bus.speed_sel)
      2'd0:    target_s = ZERO_C;
      2'd1:    target_s = LOW_C;
      2'd2:    target_s = MID_C;
      2'd3:    target_s = HIGH_C;
      default: target_s = ZERO_C;
    endcase
  end

  // Duty FSM next state; only acts on a frame wrap, otherwise holds.
  always_comb begin
    state_next_s = state_r;
    duty_next_s  = duty_r;
    duty_base_s  = duty_r;
    case (state_r)
      ST_OFF:  duty_base_s = ZERO_C;
      ST_RUN:  duty_base_s = duty_r;
`ifdef FAN_SOFTSTART_EN
      ST_RAMP: duty_base_s = duty_r;
`endif
      default: duty_base_s = ZERO_C;
    endcase
    if (wrap_s) begin
      if (target_s == ZERO_C) begin
        // Off is immediate, whatever the ramp position.
        state_next_s = ST_OFF;
        duty_next_s  = ZERO_C;
      end else begin
`ifdef FAN_SOFTSTART_EN
        duty_next_s  = step_toward(duty_base_s, target_s);
        state_next_s = (duty_next_s == target_s) ? ST_RUN : ST_RAMP;
`else
        duty_next_s  = target_s;
        state_next_s = ST_RUN;
`endif
      end
    end else begin
      state_next_s = state_r;
      duty_next_s  = duty_r;
    end
  end

  // Counter, FSM and registered outputs; pwm uses next-cycle values so it
  // lines up with the counter update.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt_r        <= ZERO_C;
      duty_r       <= ZERO_C;
      state_r      <= ST_OFF;
      pwm_r        <= 1'b0;
      frame_done_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      cnt_r        <= cnt_next_s;
      duty_r       <= duty_next_s;
      state_r      <= state_next_s;
      pwm_r        <= (cnt_next_s < duty_next_s);
      frame_done_r <= wrap_s;
`ifdef FAN_SOFTSTART_EN
      busy_r       <= (state_next_s == ST_RAMP);
`else
      busy_r       <= 1'b0;
`endif
    end
  end

  assign bus.pwm_out    = pwm_r;
  assign bus.duty_cur   = duty_r;
  assign bus.frame_done = frame_done_r;
  assign bus.busy       = busy_r;

endmodule
